dm_main_mem: RTL
================

# dm_main_mem

Line-granular backing-memory controller sitting directly downstream of the direct-mapped cache FSM. It consumes the cache's `mem_req` (128-bit line read/write, level-held `valid`) and returns `mem_data` (128-bit line + one-cycle `ready`) after a fixed, parameterised latency. It is the synthesisable memory stage and the stage-level DUT for memory-side UVM agents.

## Interface
- `DEPTH`, 1024: number of 128-bit lines; power of two, ≥2.
- `LATENCY`, 4: clocks from the request-accept edge to `ready`; ≥1.
- `IDX_W`, `$clog2(DEPTH)`: line-index width (derived, not overridden).

- `clk_i`  in  1  clock; all state on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `mem_req`  in  `mem_req_type`  {addr[31:0], data[127:0], rw, valid} from cache.
- `mem_data`  out  `mem_data_type`  {data[127:0], ready} to cache.
- `busy_o`  out  1  high while a request is accepted and not yet answered.
- `rd_cnt_o`  out  16  completed reads, wraps at 2^16.
- `wr_cnt_o`  out  16  completed writes, wraps at 2^16.

## Operation
- Line index = `mem_req.addr[4 +: IDX_W]`; addr[3:0] and bits above the index are ignored (aliasing, no error).
- Per-line written bit (DEPTH flops, reset to 0). A read of a never-written line returns 128'h0; array contents are not reset.
- FSM `mem_ctrl_state_t`: IDLE, BUSY, RESP.
  - IDLE: `mem_req.valid`=1 at an edge → latch idx, rw, data; load counter with LATENCY-1; → BUSY if LATENCY>1, else → RESP.
  - BUSY: decrement each edge; counter==0 at an edge → RESP.
  - RESP: `mem_data.ready`=1 for exactly this cycle; next edge → IDLE unconditionally.
- Read commit: entering RESP, `mem_data.data` ← array[idx], or 0 if unwritten; `rd_cnt_o`+1.
- Write commit: entering RESP, array[idx] ← latched data, written bit set; `mem_data.data` ← latched data (echo); `wr_cnt_o`+1.
- Request fields (addr, data, rw) are sampled only at the accept edge; changes during BUSY/RESP are ignored.
- `valid` may stay high continuously: the cycle after RESP is IDLE and samples whatever request is then presented. A still-high `valid` in RESP is never treated as a new request.
- `valid` dropping during BUSY does not abort; the response still issues.
- `mem_data.data` holds its last value outside RESP.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `mem_data.ready`=0, `mem_data.data`=0, `busy_o`=0, both counters 0, all written bits 0.
- Reset mid-request: pending request dropped, no array write, no counter increment; all lines read as 0 afterwards.
- Accept at edge E → `ready` high during the cycle after edge E+LATENCY-1 (LATENCY=1: the cycle right after E).
- Throughput: one request per LATENCY+1 cycles (one IDLE sample cycle between responses).
- `busy_o` high from the cycle after accept through the RESP cycle inclusive; registered.
- Write then read of the same line back-to-back: read returns the new data (commit precedes the next accept).
- Counter wrap: 16'hFFFF + 1 → 0, no flag.

## Structure
- `cache_def` package already holds `mem_req_type`, `mem_data_type`; add `mem_ctrl_state_t` and `MEM_LINE_W`=128 there.
- Sub-module `mem_line_ram`: DEPTH×128 single-port array, synchronous write, combinational read. FSM, written-bit vector and counters stay in `dm_main_mem`.

## Test plan
- Reset, then read addr 32'h0000_0040 → `ready` after 4 cycles, data 128'h0, rd_cnt_o=1, `busy_o` high 4 cycles.
- Write addr 32'h0000_0010, data {4{32'hA5A5_0001}}, then read 32'h0000_001C → read returns {4{32'hA5A5_0001}}, wr_cnt_o=1, rd_cnt_o=1.
- Aliasing: write 32'h0000_0020 (DEPTH=1024), read 32'h0000_4020 → same data returned.
- Valid held high across write→read (cache write-back/allocate pattern) → exactly two `ready` pulses, each one cycle, separated by one IDLE cycle.
- Change addr/rw/data during BUSY → response and array reflect accept-edge values only.
- Assert reset_i low in the 2nd BUSY cycle of a write to 32'h80 → `ready` never pulses, wr_cnt_o=0, later read of 32'h80 returns 0; repeat with LATENCY=1 for accept→ready timing.

Source files
------------

// File: rtl/cache_def.sv
// Shared types between the direct-mapped cache and its backing memory.
// Memory-side request/response bundles plus the memory controller states.
package cache_def;

   localparam int MEM_LINE_W = 128;

   typedef struct packed {
      logic [31:0]           addr;
      logic [MEM_LINE_W-1:0] data;
      logic                  rw;
      logic                  valid;
   } mem_req_type;

   typedef struct packed {
      logic [MEM_LINE_W-1:0] data;
      logic                  ready;
   } mem_data_type;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } mem_ctrl_state_t;

endpackage

// File: rtl/mem_line_ram.sv
// Line array behind dm_main_mem.
// Single port: synchronous write, combinational read.
module mem_line_ram
   import cache_def::*;
#(
   parameter  int DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [MEM_LINE_W-1:0] wdata,
   output logic [MEM_LINE_W-1:0] rdata
);

   logic [MEM_LINE_W-1:0] mem [DEPTH];

   // write the addressed line; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dm_main_mem.sv
// Fixed-latency line memory answering the cache's mem_req.
// FSM, written-bit vector and completion counters live here.
module dm_main_mem
   import cache_def::*;
#(
   parameter  int DEPTH   = 1024,
   parameter  int LATENCY = 4,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  mem_req_type  mem_req,
   output mem_data_type mem_data,
   output logic         busy_o,
   output logic [15:0]  rd_cnt_o,
   output logic [15:0]  wr_cnt_o
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mem_ctrl_state_t       state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx_q;
   logic                  rw_q;
   logic [MEM_LINE_W-1:0] data_q;
   logic [DEPTH-1:0]      written;

   logic                  accept;
   logic                  commit;
   logic [IDX_W-1:0]      c_idx;
   logic                  c_rw;
   logic [MEM_LINE_W-1:0] c_data;
   logic [MEM_LINE_W-1:0] rdata;
   logic                  unused_ok;

   assign accept = (state == IDLE) && mem_req.valid;

   // with LATENCY=1 the accept edge is also the commit edge,
   // so the commit fields come straight from the live request
   assign commit = (accept && (LATENCY == 1))
                || ((state == BUSY) && (cnt <= CNT_W'(1)));

   assign c_idx  = accept ? mem_req.addr[4 +: IDX_W] : idx_q;
   assign c_rw   = accept ? mem_req.rw : rw_q;
   assign c_data = accept ? mem_req.data : data_q;

   assign unused_ok = ^{mem_req.addr[3:0],
                        mem_req.addr[31:4+IDX_W]};

   mem_line_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk_i),
      .we    (commit && c_rw),
      .idx   (c_idx),
      .wdata (c_data),
      .rdata (rdata)
   );

   // request FSM with registered ready/busy/data and commit bookkeeping
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state    <= IDLE;
         cnt      <= '0;
         idx_q    <= '0;
         rw_q     <= 1'b0;
         data_q   <= '0;
         written  <= '0;
         mem_data <= '0;
         busy_o   <= 1'b0;
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else begin
         mem_data.ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mem_req.valid) begin
                  idx_q  <= mem_req.addr[4 +: IDX_W];
                  rw_q   <= mem_req.rw;
                  data_q <= mem_req.data;
                  cnt    <= CNT_W'(LATENCY - 1);
                  if (LATENCY > 1) begin
                     state  <= BUSY;
                     busy_o <= 1'b1;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
            end
            RESP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
         if (commit) begin
            state          <= RESP;
            busy_o         <= 1'b1;
            mem_data.ready <= 1'b1;
            if (c_rw) begin
               mem_data.data  <= c_data;
               written[c_idx] <= 1'b1;
               wr_cnt_o       <= wr_cnt_o + 16'd1;
            end else begin
               mem_data.data <= written[c_idx] ? rdata : '0;
               rd_cnt_o      <= rd_cnt_o + 16'd1;
            end
         end
      end
   end

endmodule
